// File: rtl/imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// imem_fetch_responder
//
// Instruction-memory responder for the instruction fetch unit. It accepts one
// fetch at a time (a 30-bit word address, i.e. PC[31:2]). After WAIT_CYCLES
// wait states it returns the 32-bit word from an internal array. The array is
// preloaded through a separate write port.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active low (array contents are kept)
//   req_valid   fetch request present
//   req_ready   responder idle and able to accept a request
//   req_addr    30-bit word address
//   resp_valid  response present
//   resp_ready  consumer takes the response
//   resp_instr  instruction word (ERR_INSTR for an out-of-range address)
//   resp_err    request address was >= DEPTH
//   wr_en       preload write strobe
//   wr_addr     preload word address
//   wr_data     preload data
// -----------------------------------------------------------------------------
module imem_fetch_responder #(
   parameter int          DEPTH       = 1024,
   parameter int          ADDR_W      = 10,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ERR_INSTR   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [29:0]       req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_instr,
   output logic              resp_err,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [29:0]        addr_reg, addr_next;
   logic               do_read;
   logic [29:0]        rd_addr;
   logic               rd_err;
   logic               wr_in_range;

   logic [31:0]        mem [DEPTH];

   // With zero wait states the array is read on the accepting edge itself,
   // so the live request address is used; otherwise the latched one.
   assign rd_addr = (state_reg == IDLE) ? req_addr : addr_reg;

   // Full 30-bit compare so that high address bits never alias into the array.
   assign rd_err  = (rd_addr >= 30'(DEPTH));

   // Writes beyond DEPTH are dropped. When the port width exactly covers the
   // array, every address is in range.
   generate
      if (DEPTH < (2 ** ADDR_W)) begin : g_wr_partial
         assign wr_in_range = (32'(wr_addr) < 32'(DEPTH));
      end else begin : g_wr_full
         assign wr_in_range = 1'b1;
      end
   endgenerate

   // State register plus the registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         addr_reg   <= '0;
         resp_instr <= '0;
         resp_err   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
         if (do_read) begin
            resp_err   <= rd_err;
            resp_instr <= rd_err ? ERR_INSTR : mem[rd_addr[ADDR_W-1:0]];
         end
      end
   end

   // Array write port. No reset, so preloaded contents survive rst_n. A write
   // to the word being read on the same edge leaves the read with the old word.
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      do_read    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               addr_next = req_addr;
               cnt_next  = CNT_W'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_next = RESP;
                  do_read    = 1'b1;
               end else begin
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            // The counter counts down the remaining wait states; the read
            // happens on the edge that takes it to zero, which gives
            // WAIT_CYCLES+1 cycles from the accepting cycle to resp_valid.
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next = RESP;
               do_read    = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decode directly from state so they follow rst_n immediately.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_reg)
         IDLE:    req_ready  = 1'b1;
         RESP:    resp_valid = 1'b1;
         default: begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// Testbench for imem_fetch_responder. Two instances run side by side, one with
// two wait states and one with none. Each lane has a driver that issues fetches
// and pushes the expected response into a queue. It also has a monitor that
// pops and compares on every response handshake and checks latency, hold
// stability and req_ready.
// -----------------------------------------------------------------------------
module tb_imem_fetch_responder;
   localparam int          DEPTH  = 1024;
   localparam int          ADDR_W = 10;
   localparam logic [31:0] ERR_W  = 32'hBAD0_BAD0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      localparam int LW = (gi == 0) ? 2 : 0;

      typedef struct {
         logic [31:0] instr;
         logic        err;
         logic [29:0] addr;
      } exp_t;

      logic              rst_n;
      logic              req_valid;
      logic              req_ready;
      logic [29:0]       req_addr;
      logic              resp_valid;
      logic              resp_ready;
      logic [31:0]       resp_instr;
      logic              resp_err;
      logic              wr_en;
      logic [ADDR_W-1:0] wr_addr;
      logic [31:0]       wr_data;

      exp_t        exp_q[$];
      logic [31:0] model_mem [DEPTH];
      int          cyc      = 0;
      int          acc_cyc  = 0;
      bit          inflight = 1'b0;
      bit          done     = 1'b0;

      imem_fetch_responder #(
         .DEPTH       (DEPTH),
         .ADDR_W      (ADDR_W),
         .WAIT_CYCLES (LW),
         .ERR_INSTR   (ERR_W)
      ) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .req_valid  (req_valid),
         .req_ready  (req_ready),
         .req_addr   (req_addr),
         .resp_valid (resp_valid),
         .resp_ready (resp_ready),
         .resp_instr (resp_instr),
         .resp_err   (resp_err),
         .wr_en      (wr_en),
         .wr_addr    (wr_addr),
         .wr_data    (wr_data)
      );

      // Monitor: samples on the falling edge.
      initial begin
         exp_t        e;
         bit          prev_valid = 1'b0;
         bit          prev_hs    = 1'b0;
         logic [31:0] prev_instr = '0;
         logic        prev_err   = 1'b0;
         forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
               prev_valid = 1'b0;
               prev_hs    = 1'b0;
            end else begin
               if (req_valid && req_ready) acc_cyc = cyc;
               if (inflight)
                  check(!req_ready, $sformatf("lane%0d_ready_while_busy", gi), 32'(req_ready), 32'h0);
               if (prev_hs)
                  check(req_ready && !resp_valid, $sformatf("lane%0d_idle_after_hs", gi),
                        32'({req_ready, resp_valid}), 32'h2);
               if (resp_valid) begin
                  if (!prev_valid)
                     check(cyc - acc_cyc == LW + 1, $sformatf("lane%0d_latency", gi),
                           32'(cyc - acc_cyc), 32'(LW + 1));
                  else
                     check(resp_instr === prev_instr && resp_err === prev_err,
                           $sformatf("lane%0d_hold_stable", gi), resp_instr, prev_instr);
                  if (resp_ready) begin
                     if (exp_q.size() == 0) begin
                        check(1'b0, $sformatf("lane%0d_unexpected_resp", gi), resp_instr, 32'h0);
                     end else begin
                        e = exp_q.pop_front();
                        check(resp_instr === e.instr, $sformatf("lane%0d_instr", gi), resp_instr, e.instr);
                        check(resp_err === e.err, $sformatf("lane%0d_err", gi), 32'(resp_err), 32'(e.err));
                        $display("[TB] lane%0d fetch addr=%h instr=%h err=%0d (want %h/%0d)",
                                 gi, e.addr, resp_instr, resp_err, e.instr, e.err);
                     end
                  end
               end
               prev_hs    = resp_valid && resp_ready;
               prev_valid = resp_valid && !resp_ready;
               prev_instr = resp_instr;
               prev_err   = resp_err;
            end
         end
      end

      task automatic mem_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
         wr_en   = 1'b1;
         wr_addr = a;
         wr_data = d;
         @(posedge clk); #1;
         wr_en = 1'b0;
         model_mem[a] = d;
      endtask

      // One fetch. Optionally writes cdata to the same word on the read edge.
      // Junk requests are driven while busy; the responder must ignore them.
      task automatic fetch(input logic [29:0] a, input int hold,
                           input bit collide, input logic [31:0] cdata);
         exp_t e;
         int   w;
         req_valid = 1'b1;
         req_addr  = a;
         wr_en     = collide && (LW == 0);
         wr_addr   = a[ADDR_W-1:0];
         wr_data   = cdata;
         @(negedge clk);
         check(req_ready, $sformatf("lane%0d_accept", gi), 32'(req_ready), 32'h1);
         e.addr = a;
         if (a < DEPTH) begin
            e.instr = model_mem[a[ADDR_W-1:0]];
            e.err   = 1'b0;
         end else begin
            e.instr = ERR_W;
            e.err   = 1'b1;
         end
         exp_q.push_back(e);
         @(posedge clk); #1;
         wr_en     = 1'b0;
         inflight  = 1'b1;
         req_valid = 1'($urandom_range(0, 1));
         req_addr  = 30'($urandom);
         for (int j = 1; j <= LW; j++) begin
            wr_en = collide && (j == LW);
            @(posedge clk); #1;
            wr_en     = 1'b0;
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 30'($urandom);
         end
         if (collide && a < DEPTH) model_mem[a[ADDR_W-1:0]] = cdata;
         resp_ready = 1'b0;
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom_range(0, 1));
         end
         req_valid  = 1'b0;
         resp_ready = 1'b1;
         w = 0;
         @(negedge clk);
         while (!resp_valid && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (!resp_valid)
            check(1'b0, $sformatf("lane%0d_resp_timeout", gi), 32'(resp_valid), 32'h1);
         @(posedge clk); #1;
         resp_ready = 1'b0;
         inflight   = 1'b0;
      endtask

      task automatic reset_mid(input logic [29:0] a);
         req_valid = 1'b1;
         req_addr  = a;
         @(negedge clk);
         check(req_ready, $sformatf("lane%0d_accept_pre_reset", gi), 32'(req_ready), 32'h1);
         @(posedge clk); #1;
         req_valid = 1'b0;
         #2;
         rst_n = 1'b0;
         #1;
         check(!resp_valid && req_ready, $sformatf("lane%0d_async_reset_hs", gi),
               32'({resp_valid, req_ready}), 32'h1);
         check(resp_instr === 32'h0 && resp_err === 1'b0, $sformatf("lane%0d_async_reset_data", gi),
               resp_instr, 32'h0);
         repeat (2) @(posedge clk);
         #3;
         rst_n = 1'b1;
         @(posedge clk); #1;
      endtask

      // Driver.
      initial begin
         logic [29:0] a;
         rst_n      = 1'b0;
         req_valid  = 1'b0;
         req_addr   = '0;
         resp_ready = 1'b0;
         wr_en      = 1'b0;
         wr_addr    = '0;
         wr_data    = '0;
         #1;
         check(req_ready === 1'b1, $sformatf("lane%0d_rst_req_ready", gi), 32'(req_ready), 32'h1);
         check(resp_valid === 1'b0, $sformatf("lane%0d_rst_resp_valid", gi), 32'(resp_valid), 32'h0);
         check(resp_instr === 32'h0, $sformatf("lane%0d_rst_resp_instr", gi), resp_instr, 32'h0);
         check(resp_err === 1'b0, $sformatf("lane%0d_rst_resp_err", gi), 32'(resp_err), 32'h0);
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b1;

         for (int i = 0; i < DEPTH; i++)
            mem_write(ADDR_W'(i), (i < 4) ? (32'h1111_0000 + 32'(i)) : $urandom);

         fetch(30'd2, 0, 1'b0, 32'h0);
         fetch(30'd1, 0, 1'b0, 32'h0);
         fetch(30'd2, 5, 1'b0, 32'h0);
         fetch(30'h3FFF_FFFF, 1, 1'b0, 32'h0);
         fetch(30'd0, 0, 1'b0, 32'h0);
         fetch(30'(DEPTH), 0, 1'b0, 32'h0);
         fetch(30'(DEPTH - 1), 0, 1'b0, 32'h0);
         fetch(30'(DEPTH + 2), 0, 1'b0, 32'h0);
         fetch(30'd2, 0, 1'b1, 32'hDEAD_BEEF);
         fetch(30'd2, 0, 1'b0, 32'h0);
         reset_mid(30'd1);
         fetch(30'd3, 0, 1'b0, 32'h0);

         for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
               mem_write(ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom);
            if ($urandom_range(0, 3) != 0)
               a = 30'($urandom_range(0, DEPTH - 1));
            else
               a = 30'($urandom_range(DEPTH, 32'h3FFF_FFFF));
            fetch(a, int'($urandom_range(0, 3)),
                  (a < DEPTH) && ($urandom_range(0, 2) == 0), $urandom);
         end

         repeat (3) @(posedge clk);
         #1;
         check(exp_q.size() == 0, $sformatf("lane%0d_queue_drain", gi), 32'(exp_q.size()), 32'h0);
         done = 1'b1;
      end
   end

   initial begin
      int n = 0;
      while (!(g_lane[0].done && g_lane[1].done) && n < 60000) begin
         @(posedge clk);
         n++;
      end
      if (!(g_lane[0].done && g_lane[1].done))
         check(1'b0, "global_timeout", 32'(n), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
